// File: rtl/plotter_pkg.sv
// Shared plotter definitions: coil phase table, direction encoding and default widths.
package plotter_pkg;

  localparam int unsigned POS_WIDTH_DEFAULT = 16;
  localparam int unsigned PHASE_W           = 3;
  localparam int unsigned COIL_W            = 4;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  typedef logic [PHASE_W-1:0] phase_t;
  typedef logic [COIL_W-1:0]  coil_t;

  // Coil drive {A, B, A', B'} per phase; entry 0 is the rightmost element.
  localparam logic [7:0][COIL_W-1:0] COIL_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  function automatic coil_t coil_of(input phase_t ph, input logic en);
    coil_t c;
    c = '0;
    if (en) c = COIL_TABLE[ph];
    return c;
  endfunction

endpackage

// File: rtl/step_dir_sync.sv
// Synchronizes the asynchronous step/dir lines and detects rising step edges,
// refusing a first edge after reset until step has been seen low.
module step_dir_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic step_in,
  input  logic dir_in,
  output logic step_pulse,
  output logic dir_sync
);

  logic [SYNC_STAGES-1:0] step_q;
  logic [SYNC_STAGES-1:0] dir_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   step_sync;

  assign step_sync = step_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_q  <= '0;
      dir_q   <= '0;
      vld_q   <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      step_q  <= {step_q[SYNC_STAGES-2:0], step_in};
      dir_q   <= {dir_q[SYNC_STAGES-2:0], dir_in};
      vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= step_sync;
      // Arm only once a genuinely sampled low has reached the end of the chain.
      armed_q <= armed_q | (vld_q[SYNC_STAGES-1] & ~step_sync);
    end
  end

  assign step_pulse = step_sync & ~prev_q & armed_q;
  assign dir_sync   = dir_q[SYNC_STAGES-1];

endmodule

// File: rtl/step_dir_decoder.sv
// Per-axis step/dir receiver: decodes step edges into coil phase and signed
// position, with minimum step interval, soft travel limits and sticky faults.
module step_dir_decoder
  import plotter_pkg::*;
#(
  parameter int unsigned                 POS_WIDTH       = 16,
  parameter int unsigned                 SYNC_STAGES     = 2,
  parameter int unsigned                 MIN_STEP_CYCLES = 64,
  parameter logic signed [POS_WIDTH-1:0] POS_MIN         = -16'sd30000,
  parameter logic signed [POS_WIDTH-1:0] POS_MAX         = 16'sd30000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        step_in,
  input  logic                        dir_in,
  input  logic                        enable,
  input  logic                        half_step,
  input  logic                        zero_pos,
  input  logic                        clear_fault,
  output logic [COIL_W-1:0]           coil,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        at_limit,
  output logic                        fault_overspeed,
  output logic                        fault_limit
);

  localparam int unsigned GAP_W = $clog2(MIN_STEP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(MIN_STEP_CYCLES);

  logic                        step_pulse;
  logic                        dir_sync;

  logic signed [POS_WIDTH-1:0] position_q, position_d;
  phase_t                      phase_q, phase_d;
  logic [GAP_W-1:0]            gap_q, gap_d;
  coil_t                       coil_q, coil_d;
  logic                        ovs_q, ovs_d;
  logic                        lim_q, lim_d;

  logic   step_en, too_soon, blocked, accept, reject_speed, reject_limit;
  phase_t phase_delta;

  step_dir_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .resetn    (resetn),
    .step_in   (step_in),
    .dir_in    (dir_in),
    .step_pulse(step_pulse),
    .dir_sync  (dir_sync)
  );

  // Step qualification: interval check outranks the limit check.
  always_comb begin
    step_en      = step_pulse & enable;
    too_soon     = gap_q < GAP_SAT;
    blocked      = (dir_sync == DIR_POS) ? (position_q >= POS_MAX) : (position_q <= POS_MIN);
    reject_speed = step_en & too_soon;
    reject_limit = step_en & ~too_soon & blocked;
    accept       = step_en & ~too_soon & ~blocked;
    phase_delta  = half_step ? PHASE_W'(1) : PHASE_W'(2);
  end

  always_comb begin
    position_d = position_q;
    phase_d    = phase_q;
    gap_d      = (gap_q == GAP_SAT) ? gap_q : gap_q + GAP_W'(1);
    coil_d     = coil_of(phase_q, enable);
    ovs_d      = (ovs_q & ~clear_fault) | reject_speed;
    lim_d      = (lim_q & ~clear_fault) | reject_limit;

    if (accept) begin
      gap_d = '0;
      if (dir_sync == DIR_POS) begin
        position_d = position_q + POS_WIDTH'(1);
        phase_d    = phase_q + phase_delta;
      end else begin
        position_d = position_q - POS_WIDTH'(1);
        phase_d    = phase_q - phase_delta;
      end
    end

    if (zero_pos) position_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      position_q <= '0;
      phase_q    <= '0;
      gap_q      <= GAP_SAT;
      coil_q     <= '0;
      ovs_q      <= 1'b0;
      lim_q      <= 1'b0;
    end else begin
      position_q <= position_d;
      phase_q    <= phase_d;
      gap_q      <= gap_d;
      coil_q     <= coil_d;
      ovs_q      <= ovs_d;
      lim_q      <= lim_d;
    end
  end

  assign coil            = coil_q;
  assign position        = position_q;
  assign fault_overspeed = ovs_q;
  assign fault_limit     = lim_q;
  assign at_limit        = (position_q == POS_MIN) | (position_q == POS_MAX);

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder with shrunken travel limits (-4..6).
module tb_step_dir_decoder;

  logic               clk;
  logic               resetn;
  logic               step_in;
  logic               dir_in;
  logic               enable;
  logic               half_step;
  logic               zero_pos;
  logic               clear_fault;
  logic [3:0]         coil;
  logic signed [15:0] position;
  logic               at_limit;
  logic               fault_overspeed;
  logic               fault_limit;

  int n_tests = 0;
  int n_fail  = 0;

  step_dir_decoder #(
    .POS_WIDTH      (16),
    .SYNC_STAGES    (2),
    .MIN_STEP_CYCLES(64),
    .POS_MIN        (-16'sd4),
    .POS_MAX        (16'sd6)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .step_in        (step_in),
    .dir_in         (dir_in),
    .enable         (enable),
    .half_step      (half_step),
    .zero_pos       (zero_pos),
    .clear_fault    (clear_fault),
    .coil           (coil),
    .position       (position),
    .at_limit       (at_limit),
    .fault_overspeed(fault_overspeed),
    .fault_limit    (fault_limit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    resetn      = 1'b0;
    step_in     = 1'b0;
    dir_in      = 1'b0;
    enable      = 1'b0;
    half_step   = 1'b0;
    zero_pos    = 1'b0;
    clear_fault = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Rise-to-rise spacing of consecutive calls is tail + 7 cycles.
  task automatic do_step(input logic d, input int tail);
    @(negedge clk);
    dir_in = d;
    repeat (3) @(negedge clk);
    step_in = 1'b1;
    repeat (3) @(negedge clk);
    step_in = 1'b0;
    repeat (tail) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (coil !== 4'b0000) begin n_fail++; $display("FAIL reset_coil: got %b want 0000", coil); end
    n_tests++; if (position !== 16'sd0) begin n_fail++; $display("FAIL reset_pos: got %0d want 0", position); end
    n_tests++; if (at_limit !== 1'b0) begin n_fail++; $display("FAIL reset_at_limit: got %b want 0", at_limit); end
    n_tests++; if (fault_overspeed !== 1'b0) begin n_fail++; $display("FAIL reset_ovs: got %b want 0", fault_overspeed); end
    n_tests++; if (fault_limit !== 1'b0) begin n_fail++; $display("FAIL reset_lim: got %b want 0", fault_limit); end
  endtask

  task automatic test_half_step_pos();
    apply_reset();
    enable = 1'b1; half_step = 1'b1; dir_in = 1'b1;
    repeat (5) @(negedge clk);
    step_in = 1'b1;
    @(negedge clk);
    n_tests++; if (position !== 16'sd0) begin n_fail++; $display("FAIL lat_k: got %0d want 0", position); end
    @(negedge clk);
    n_tests++; if (position !== 16'sd0) begin n_fail++; $display("FAIL lat_k1: got %0d want 0", position); end
    @(negedge clk);
    n_tests++; if (position !== 16'sd1) begin n_fail++; $display("FAIL lat_k2_pos: got %0d want 1", position); end
    n_tests++; if (coil !== 4'b1000) begin n_fail++; $display("FAIL lat_k2_coil: got %b want 1000", coil); end
    @(negedge clk);
    n_tests++; if (coil !== 4'b1100) begin n_fail++; $display("FAIL lat_k3_coil: got %b want 1100", coil); end
    step_in = 1'b0;
    repeat (90) @(negedge clk);
    repeat (4) do_step(1'b1, 93);
    n_tests++; if (position !== 16'sd5) begin n_fail++; $display("FAIL half_pos: got %0d want 5", position); end
    n_tests++; if (coil !== 4'b0011) begin n_fail++; $display("FAIL half_coil: got %b want 0011", coil); end
  endtask

  task automatic test_full_step_neg();
    apply_reset();
    enable = 1'b1; half_step = 1'b0;
    repeat (3) do_step(1'b0, 70);
    n_tests++; if (position !== -16'sd3) begin n_fail++; $display("FAIL full_pos: got %0d want -3", position); end
    n_tests++; if (coil !== 4'b0100) begin n_fail++; $display("FAIL full_coil: got %b want 0100", coil); end
  endtask

  task automatic test_overspeed();
    apply_reset();
    enable = 1'b1; half_step = 1'b1;
    do_step(1'b1, 3);
    do_step(1'b1, 5);
    n_tests++; if (position !== 16'sd1) begin n_fail++; $display("FAIL ovs_pos: got %0d want 1", position); end
    n_tests++; if (fault_overspeed !== 1'b1) begin n_fail++; $display("FAIL ovs_set: got %b want 1", fault_overspeed); end
    n_tests++; if (fault_limit !== 1'b0) begin n_fail++; $display("FAIL ovs_lim: got %b want 0", fault_limit); end
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    @(negedge clk);
    n_tests++; if (fault_overspeed !== 1'b0) begin n_fail++; $display("FAIL ovs_clear: got %b want 0", fault_overspeed); end
    repeat (70) @(negedge clk);
    do_step(1'b1, 5);
    n_tests++; if (position !== 16'sd2) begin n_fail++; $display("FAIL ovs_after: got %0d want 2", position); end
    n_tests++; if (fault_overspeed !== 1'b0) begin n_fail++; $display("FAIL ovs_after_flag: got %b want 0", fault_overspeed); end
  endtask

  task automatic test_limits();
    apply_reset();
    enable = 1'b1; half_step = 1'b1;
    repeat (6) do_step(1'b1, 70);
    n_tests++; if (position !== 16'sd6) begin n_fail++; $display("FAIL max_pos: got %0d want 6", position); end
    n_tests++; if (at_limit !== 1'b1) begin n_fail++; $display("FAIL max_at_limit: got %b want 1", at_limit); end
    n_tests++; if (fault_limit !== 1'b0) begin n_fail++; $display("FAIL max_no_fault: got %b want 0", fault_limit); end
    do_step(1'b1, 70);
    n_tests++; if (position !== 16'sd6) begin n_fail++; $display("FAIL max_hold: got %0d want 6", position); end
    n_tests++; if (fault_limit !== 1'b1) begin n_fail++; $display("FAIL max_fault: got %b want 1", fault_limit); end
    n_tests++; if (fault_overspeed !== 1'b0) begin n_fail++; $display("FAIL max_ovs: got %b want 0", fault_overspeed); end
    do_step(1'b0, 70);
    n_tests++; if (position !== 16'sd5) begin n_fail++; $display("FAIL max_back: got %0d want 5", position); end
    n_tests++; if (at_limit !== 1'b0) begin n_fail++; $display("FAIL max_back_lim: got %b want 0", at_limit); end
    n_tests++; if (fault_limit !== 1'b1) begin n_fail++; $display("FAIL max_sticky: got %b want 1", fault_limit); end
    apply_reset();
    enable = 1'b1;
    repeat (5) do_step(1'b0, 70);
    n_tests++; if (position !== -16'sd4) begin n_fail++; $display("FAIL min_pos: got %0d want -4", position); end
    n_tests++; if (at_limit !== 1'b1) begin n_fail++; $display("FAIL min_at_limit: got %b want 1", at_limit); end
    n_tests++; if (fault_limit !== 1'b1) begin n_fail++; $display("FAIL min_fault: got %b want 1", fault_limit); end
  endtask

  task automatic test_enable_zero();
    apply_reset();
    enable = 1'b1; half_step = 1'b1;
    do_step(1'b1, 70);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (coil !== 4'b0000) begin n_fail++; $display("FAIL dis_coil: got %b want 0000", coil); end
    repeat (4) do_step(1'b1, 10);
    n_tests++; if (position !== 16'sd1) begin n_fail++; $display("FAIL dis_pos: got %0d want 1", position); end
    n_tests++; if (fault_overspeed !== 1'b0) begin n_fail++; $display("FAIL dis_ovs: got %b want 0", fault_overspeed); end
    enable = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (coil !== 4'b1100) begin n_fail++; $display("FAIL en_coil: got %b want 1100", coil); end
    dir_in = 1'b1;
    repeat (3) @(negedge clk);
    step_in = 1'b1;
    repeat (2) @(negedge clk);
    zero_pos = 1'b1;
    @(negedge clk);
    zero_pos = 1'b0;
    n_tests++; if (position !== 16'sd0) begin n_fail++; $display("FAIL zero_pos: got %0d want 0", position); end
    @(negedge clk);
    step_in = 1'b0;
    n_tests++; if (coil !== 4'b0100) begin n_fail++; $display("FAIL zero_phase: got %b want 0100", coil); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    enable = 1'b1; half_step = 1'b1;
    do_step(1'b1, 3);
    do_step(1'b1, 5);
    n_tests++; if (fault_overspeed !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ovs: got %b want 1", fault_overspeed); end
    repeat (70) @(negedge clk);
    dir_in = 1'b1;
    repeat (3) @(negedge clk);
    step_in = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_tests++; if (position !== 16'sd0) begin n_fail++; $display("FAIL mid_pos: got %0d want 0", position); end
    n_tests++; if (coil !== 4'b0000) begin n_fail++; $display("FAIL mid_coil: got %b want 0000", coil); end
    n_tests++; if (fault_overspeed !== 1'b0) begin n_fail++; $display("FAIL mid_ovs: got %b want 0", fault_overspeed); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++; if (position !== 16'sd0) begin n_fail++; $display("FAIL mid_no_step: got %0d want 0", position); end
    n_tests++; if (coil !== 4'b1000) begin n_fail++; $display("FAIL mid_coil_rel: got %b want 1000", coil); end
    step_in = 1'b0;
    repeat (5) @(negedge clk);
    do_step(1'b1, 5);
    n_tests++; if (position !== 16'sd1) begin n_fail++; $display("FAIL mid_next_step: got %0d want 1", position); end
  endtask

  initial begin
    test_reset();
    test_half_step_pos();
    test_full_step_neg();
    test_overspeed();
    test_limits();
    test_enable_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
